register_bank_mp: RTL

REGISTER_BANK_MP -- requirements
Module: register_bank_mp

---
 rtl/register_bank_mp_pkg.sv | 16 +
 rtl/register_bank_mp_reg_scoreboard.sv | 63 ++++++
 rtl/register_bank_mp.sv | 87 ++++++++
 3 files changed

// File: rtl/register_bank_mp_pkg.sv
// Shared processor package: register bank defaults and packed-lane index helper.
package register_bank_mp_pkg;

    localparam int unsigned DEF_ADDRESS_SIZE  = 5;
    localparam int unsigned DEF_REGISTER_SIZE = 8;
    localparam int unsigned DEF_READ_PORTS    = 2;
    localparam int unsigned DEF_ZERO_REG      = 1;
    localparam int unsigned DEF_BYPASS        = 1;
    localparam int unsigned MAX_READ_PORTS    = 4;

    // Low bit of lane 'lane' in a bus packing lanes of 'width' bits each.
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/register_bank_mp_reg_scoreboard.sv
// Pending-register scoreboard: one pending bit per register plus a running population count.
module reg_scoreboard
    import register_bank_mp_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = DEF_ADDRESS_SIZE,
    parameter int unsigned READ_PORTS   = DEF_READ_PORTS,
    parameter int unsigned ZERO_REG     = DEF_ZERO_REG
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               write0,
    input  logic                               write1,
    input  logic [ADDRESS_SIZE-1:0]            addr_in0,
    input  logic [ADDRESS_SIZE-1:0]            addr_in1,
    input  logic                               claim,
    input  logic [ADDRESS_SIZE-1:0]            claim_addr,
    input  logic [READ_PORTS*ADDRESS_SIZE-1:0] addr_out,
    output logic [READ_PORTS-1:0]              pending_out,
    output logic [ADDRESS_SIZE:0]              pending_count
);

    localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;
    localparam int unsigned CNT_W = ADDRESS_SIZE + 1;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             claim_eff;
    logic             inc;
    logic             clr0;
    logic             clr1;

    // Next pending vector and count delta; a claim overrides a write clear on the same register.
    always_comb begin
        claim_eff = claim && !(ZERO_REG != 0 && claim_addr == '0);
        inc       = claim_eff && !pend[claim_addr];
        clr0      = write0 && pend[addr_in0] && !(claim_eff && claim_addr == addr_in0);
        clr1      = write1 && pend[addr_in1] && !(claim_eff && claim_addr == addr_in1)
                    && !(clr0 && addr_in1 == addr_in0);
        pend_nxt  = pend;
        if (clr0) pend_nxt[addr_in0] = 1'b0;
        if (clr1) pend_nxt[addr_in1] = 1'b0;
        if (claim_eff) pend_nxt[claim_addr] = 1'b1;
        count_nxt = pending_count + CNT_W'(inc) - CNT_W'(clr0) - CNT_W'(clr1);
    end

    // Pending bits and counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend          <= '0;
            pending_count <= '0;
        end else begin
            pend          <= pend_nxt;
            pending_count <= count_nxt;
        end
    end

    // Registered pending bit per read port, no same-cycle forwarding.
    for (genvar k = 0; k < READ_PORTS; k++) begin : g_pend
        assign pending_out[k] = pend[addr_out[lane_lo(k, ADDRESS_SIZE) +: ADDRESS_SIZE]];
    end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-read-port register bank with two write ports, optional zero register, write bypass and pending scoreboard.
module register_bank_mp
    import register_bank_mp_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE  = DEF_ADDRESS_SIZE,
    parameter int unsigned REGISTER_SIZE = DEF_REGISTER_SIZE,
    parameter int unsigned READ_PORTS    = DEF_READ_PORTS,
    parameter int unsigned ZERO_REG      = DEF_ZERO_REG,
    parameter int unsigned BYPASS        = DEF_BYPASS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                write0,
    input  logic                                write1,
    input  logic [ADDRESS_SIZE-1:0]             addr_in0,
    input  logic [ADDRESS_SIZE-1:0]             addr_in1,
    input  logic [REGISTER_SIZE-1:0]            data_in0,
    input  logic [REGISTER_SIZE-1:0]            data_in1,
    input  logic [READ_PORTS*ADDRESS_SIZE-1:0]  addr_out,
    output logic [READ_PORTS*REGISTER_SIZE-1:0] data_out,
    input  logic                                claim,
    input  logic [ADDRESS_SIZE-1:0]             claim_addr,
    output logic [READ_PORTS-1:0]               pending_out,
    output logic [ADDRESS_SIZE:0]               pending_count
);

    localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;

    if (READ_PORTS < 1 || READ_PORTS > MAX_READ_PORTS) begin : g_bad_read_ports
        $error("register_bank_mp: READ_PORTS must be in 1..4");
    end

    logic [REGISTER_SIZE-1:0] regs [DEPTH];
    logic                     wr0_ok;
    logic                     wr1_ok;

    assign wr0_ok = write0 && !(ZERO_REG != 0 && addr_in0 == '0);
    assign wr1_ok = write1 && !(ZERO_REG != 0 && addr_in1 == '0);

    // Storage array; port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '{default: '0};
        end else begin
            if (wr0_ok) regs[addr_in0] <= data_in0;
            if (wr1_ok) regs[addr_in1] <= data_in1;
        end
    end

    // Combinational read mux per port, held at zero while reset is asserted.
    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [ADDRESS_SIZE-1:0]  ra;
        logic [REGISTER_SIZE-1:0] rd;

        assign ra = addr_out[lane_lo(k, ADDRESS_SIZE) +: ADDRESS_SIZE];

        // Zero register, then bypass (port 1 first), then stored value.
        always_comb begin
            rd = regs[ra];
            if (BYPASS != 0 && write0 && addr_in0 == ra) rd = data_in0;
            if (BYPASS != 0 && write1 && addr_in1 == ra) rd = data_in1;
            if (ZERO_REG != 0 && ra == '0) rd = '0;
            if (!reset) rd = '0;
        end

        assign data_out[lane_lo(k, REGISTER_SIZE) +: REGISTER_SIZE] = rd;
    end

    reg_scoreboard #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .READ_PORTS   (READ_PORTS),
        .ZERO_REG     (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .write0        (write0),
        .write1        (write1),
        .addr_in0      (addr_in0),
        .addr_in1      (addr_in1),
        .claim         (claim),
        .claim_addr    (claim_addr),
        .addr_out      (addr_out),
        .pending_out   (pending_out),
        .pending_count (pending_count)
    );

endmodule
